// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and frame-word helper for the ADC SPI master.
// Scan mode (ADC_SCAN_EN) is handled in adc_spi_master.sv.
package adc_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_W     = 12;
  localparam int ADC_CH_W       = 3;
  localparam int ADC_ADDR_MSB   = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } adc_state_t;

  function automatic logic [ADC_FRAME_BITS-1:0] frame_word(
    input logic [ADC_CH_W-1:0] a
  );
    return {2'b00, a, 11'b0};
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider: free-runs while enabled, toggles SCLK only when gated in.
// tick/rise/fall flag the clk whose closing edge moves the divider/SCLK.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic gate,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = en && (div == DW'(CLK_DIV - 1));
  assign rise = tick && gate && !sclk;
  assign fall = tick && gate && sclk;

  // Divider wraps at CLK_DIV-1; SCLK parks high whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      div  <= '0;
      sclk <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (rise)
        sclk <= 1'b1;
      else if (fall)
        sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Frame sequencer for an ADC128S022-style 8-channel 12-bit SPI ADC.
// Define ADC_SCAN_EN to address channels from an internal 0..7 scan counter.
module adc_spi_master
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int IDLE_HALVES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADC_CH_W-1:0]   ch_sel,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  output logic [ADC_DATA_W-1:0] sample,
  output logic [ADC_CH_W-1:0]   sample_ch,
  output logic                  sample_valid,
  output logic                  busy
);

  adc_state_t state;

  logic [4:0]              cnt;
  logic [ADC_CH_W-1:0]     addr;
  logic [ADC_CH_W-1:0]     prev_addr;
  logic [ADC_CH_W-1:0]     next_addr;
  logic [ADC_DATA_W-1:0]   shreg;
  logic [ADC_FRAME_BITS-1:0] word;
  logic [4:0]              fall_k;
  logic [3:0]              bit_idx;
  logic                    en;
  logic                    gate;
  logic                    tick;
  logic                    rise;
  logic                    fall;

`ifdef ADC_SCAN_EN
  logic [ADC_CH_W-1:0] scan_cnt;
  assign next_addr = scan_cnt;
`else
  assign next_addr = ch_sel;
`endif

  assign en   = (state != IDLE);
  assign gate = (state == SETUP) || (state == SHIFT);
  assign word = frame_word(addr);

  // Falling edge k follows tick 2k-1 of SHIFT (k=0 closes SETUP).
  always_comb begin
    fall_k  = (cnt + 5'd1) >> 1;
    bit_idx = 4'(5'd15 - fall_k);
  end

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .gate  (gate),
    .sclk  (adc_sclk),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall)
  );

  // Frame FSM: address out on SCLK fall, data in on SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      prev_addr    <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_din      <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            addr     <= next_addr;
            cnt      <= '0;
          end
        end
        SETUP: begin
          if (fall) begin
            state   <= SHIFT;
            adc_din <= word[bit_idx];
          end
        end
        SHIFT: begin
          if (tick) begin
            cnt <= cnt + 5'd1;
            if (fall)
              adc_din <= word[bit_idx];
            if (rise) begin
              shreg <= {shreg[ADC_DATA_W-2:0], adc_dout};
              if (cnt == 5'd30)
                state <= DONE;
            end
          end
        end
        DONE: begin
          if (tick) begin
            state        <= HOLD;
            adc_cs_n     <= 1'b1;
            sample_valid <= 1'b1;
            sample       <= shreg;
            sample_ch    <= prev_addr;
            prev_addr    <= addr;
            cnt          <= '0;
          end
        end
        HOLD: begin
          if (tick) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'(IDLE_HALVES - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SCAN_EN
  // Scan counter steps once per completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scan_cnt <= '0;
    else if (state == DONE && tick)
      scan_cnt <= scan_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_adc_spi_master.sv
// Scoreboard bench for adc_spi_master: CLK_DIV=4 instance with an ADC model,
// plus a CLK_DIV=1 instance with start held high for frame timing.
module tb_adc_spi_master;

  localparam int D  = 4;
  localparam int IH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, adc_dout;
  logic [2:0]  ch_sel;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid, busy;
  logic [11:0] sample;
  logic [2:0]  sample_ch;

  logic        rst_n2, start2, adc_dout2;
  logic [2:0]  ch_sel2;
  logic        adc_cs_n2, adc_sclk2, adc_din2, sample_valid2, busy2;
  logic [11:0] sample2;
  logic [2:0]  sample_ch2;

  adc_spi_master #(.CLK_DIV(D), .IDLE_HALVES(IH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
    .adc_dout(adc_dout), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_din(adc_din), .sample(sample), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy)
  );

  adc_spi_master #(.CLK_DIV(1), .IDLE_HALVES(IH)) dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .ch_sel(ch_sel2),
    .adc_dout(adc_dout2), .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2),
    .adc_din(adc_din2), .sample(sample2), .sample_ch(sample_ch2),
    .sample_valid(sample_valid2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int data;
    int ch;
    int edge_no;
  } exp_t;

  exp_t sbq[$];

  // sample_valid must appear 33*D edges after the start-sampling edge
  // (cycle 1+33*D when the cycle after that edge is cycle 1).
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_valid", 32'(sample_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("sample", 32'(sample), 32'(e.data));
        check("sample_ch", 32'(sample_ch), 32'(e.ch));
        check("latency", 32'(cyc - e.edge_no), 32'(33 * D));
      end
    end
  end

  // ---------------- ADC model (instance 1) ----------------
  logic [11:0] adc_word;
  logic [15:0] tx, rx, exp_word;
  int fk = 0;
  int rk = 0;

  always @(negedge adc_cs_n) begin
    tx = {4'b0, adc_word};
    fk = 0;
    rk = 0;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && fk < 16)
      adc_dout = tx[15 - fk];
    fk++;
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      rx = {rx[14:0], adc_din};
      rk++;
      if (rk == 16)
        check("din_word", 32'(rx), 32'(exp_word));
    end
  end

  // ---------------- reference model state ----------------
  int m_prev = 0;
  int m_scan = 0;

  task automatic do_frame(input int ch, input int data);
    int a;
`ifdef ADC_SCAN_EN
    a = m_scan;
`else
    a = ch;
`endif
    exp_word = 16'(a << 11);
    adc_word = 12'(data);
    sbq.push_back('{data: data, ch: m_prev, edge_no: cyc + 1});
    ch_sel = 3'(ch);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    ch_sel = 3'($urandom_range(0, 7));
    m_prev = a;
    m_scan = (m_scan + 1) % 8;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  // ---------------- instance 2 monitor (CLK_DIV=1) ----------------
  logic cs2_q = 1'b1;
  logic sc2_q = 1'b1;
  int   last_fall2 = 0;
  int   nfall2 = 0;
  int   rises2 = 0;
  int   hb2 = 0;
  int   v2 = 0;
  int   exp_ch2;

  always @(negedge clk) begin
    if (rst_n2) begin
      if (adc_sclk2 && !sc2_q && !adc_cs_n2)
        rises2++;
      if (adc_cs_n2 && busy2)
        hb2++;
      if (!adc_cs_n2 && cs2_q) begin
        if (nfall2 > 0) begin
          check("period2", 32'(cyc - last_fall2), 32'(1 + (33 + IH)));
          check("rises2", 32'(rises2), 32'd16);
          check("cs_high_hold2", 32'(hb2), 32'(IH));
        end
        rises2 = 0;
        hb2 = 0;
        last_fall2 = cyc;
        nfall2++;
      end
      if (sample_valid2 === 1'b1) begin
`ifdef ADC_SCAN_EN
        exp_ch2 = (v2 == 0) ? 0 : (v2 - 1) % 8;
`else
        exp_ch2 = (v2 == 0) ? 0 : 6;
`endif
        check("sample_ch2", 32'(sample_ch2), 32'(exp_ch2));
        check("sample2", 32'(sample2), 32'd0);
        v2++;
      end
`ifdef ADC_SCAN_EN
      ch_sel2 = 3'($urandom_range(0, 7));
`endif
    end
    cs2_q = adc_cs_n2;
    sc2_q = adc_sclk2;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst_n     = 1'b0;
    rst_n2    = 1'b0;
    start     = 1'b0;
    start2    = 1'b1;
    ch_sel    = 3'd0;
    ch_sel2   = 3'd6;
    adc_dout  = 1'b0;
    adc_dout2 = 1'b0;
    adc_word  = 12'd0;
    exp_word  = 16'd0;
    rx        = 16'd0;
    tx        = 16'd0;
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_din", 32'(adc_din), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sample_ch", 32'(sample_ch), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    rst_n  = 1'b1;
    rst_n2 = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(5, 'hA5C);
    wait_idle();
    do_frame(2, 'h123);
    wait_idle();

    repeat (5) begin
      do_frame($urandom_range(0, 7), $urandom_range(0, 4095));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // start while busy is ignored: exactly one result expected
    do_frame(3, $urandom_range(0, 4095));
    repeat (48) @(negedge clk);
    ch_sel = 3'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("pending_after_busy_start", 32'(sbq.size()), 32'd0);
    check("busy_after_hold", 32'(busy), 32'd0);

    // reset mid-frame after rising edge 7
    do_frame(4, $urandom_range(0, 4095));
    t = 0;
    while (rk < 8 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reached_rise7", 32'(rk >= 8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(adc_cs_n), 32'd1);
    check("abort_sclk", 32'(adc_sclk), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(sample_valid), 32'd0);
    void'(sbq.pop_back());
    m_prev = 0;
    m_scan = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(6, $urandom_range(0, 4095));
    wait_idle();
    do_frame($urandom_range(0, 7), $urandom_range(0, 4095));
    wait_idle();
    repeat (10) @(negedge clk);

    check("pending_end", 32'(sbq.size()), 32'd0);
    check("frames2_seen", 32'(v2 >= 9), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
